// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for seq_divider.
interface seq_divider_if import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // The shifted remainder can exceed WIDTH bits when divisor > 2^(WIDTH-1),
  // so the carry-out is kept and the subtract is one bit wider.
  assign shifted = {rem_i, bit_i};
  assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
  assign q_o     = ~trial[WIDTH+1];
  assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement truncating division.
module seq_divider import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, dvd_q, dvd_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             zero_q, zero_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] step_rem, a_mag, b_mag, q_raw, q_fin, r_fin;
  logic             step_q, accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quot_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign q_raw = {quot_q[WIDTH-2:0], step_q};

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  assign a_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign b_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
  assign q_fin = qneg_q ? (~q_raw + 1'b1) : q_raw;
  assign r_fin = rneg_q ? (~step_rem + 1'b1) : step_rem;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fin = q_raw;
  assign r_fin = step_rem;
`endif

  assign accept = bus.start && (state_q != S_RUN);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif
    case (state_q)
      S_RUN: begin
        rem_d   = step_rem;
        quot_d  = q_raw;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d     = S_DONE;
          quotient_d  = zero_q ? '1    : q_fin;
          remainder_d = zero_q ? dvd_q : r_fin;
          dbz_d       = zero_q;
        end
      end
      default: begin
        if (accept) begin
          // A zero divisor still spends one RUN cycle so done lands two cycles after start.
          zero_d  = (bus.divisor == '0);
          count_d = (bus.divisor == '0) ? CW'(1) : CW'(WIDTH);
          dvd_d   = bus.dividend;
          dvs_d   = b_mag;
          quot_d  = a_mag;
          rem_d   = '0;
          dbz_d   = 1'b0;
          state_d = S_RUN;
`ifdef DIV_SIGNED_EN
          qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rneg_d  = bus.dividend[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign bus.ready       = (state_q != S_RUN);
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8); signed cases run when DIV_SIGNED_EN is defined.
module tb_seq_divider;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(8)) bus();
  seq_divider #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.lat = 2;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa, sbv, qi, ri;
      sa  = $signed(a);
      sbv = $signed(b);
      qi  = sa / sbv;
      ri  = sa % sbv;
      e.q = qi[7:0];
      e.r = ri[7:0];
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.dbz = 1'b0; e.lat = 9;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; the following posedge accepts the start.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit track);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (track) push_exp(a, b);
  endtask

  task automatic wait_done(input string name, input bit inject);
    int  n = 0;
    bit  got = 0;
    exp_t e;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (inject && n == 3) begin
        bus.start = 1'b1; bus.dividend = 8'd20; bus.divisor = 8'd3;
      end
      if (inject && n == 4) begin
        bus.start = 1'b0;
        nchk++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
          nerr++;
          $display("FAIL %s run_flags: ready=%b busy=%b want ready=0 busy=1", name, bus.ready, bus.busy);
        end
      end
      if (bus.done === 1'b1) got = 1;
    end
    nchk++;
    if (!got) begin
      nerr++;
      $display("FAIL %s timeout: no done within 20 cycles", name);
    end else if (sb.size() == 0) begin
      nerr++;
      $display("FAIL %s unexpected done: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (n !== e.lat) begin
        nerr++; $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
      end
      nchk++;
      if (bus.quotient !== e.q) begin
        nerr++; $display("FAIL %s quotient: got %0d want %0d", name, bus.quotient, e.q);
      end
      nchk++;
      if (bus.remainder !== e.r) begin
        nerr++; $display("FAIL %s remainder: got %0d want %0d", name, bus.remainder, e.r);
      end
      nchk++;
      if (bus.div_by_zero !== e.dbz || bus.ready !== 1'b1) begin
        nerr++;
        $display("FAIL %s flags: dbz=%b ready=%b want dbz=%b ready=1", name, bus.div_by_zero, bus.ready, e.dbz);
      end
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    nchk++;
    if (seen != 0) begin
      nerr++; $display("FAIL %s spurious_done: got %0d pulses want 0", name, seen);
    end
  endtask

  task automatic check_reset_outs(input string name);
    nchk++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.quotient !== 8'd0 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
      nerr++;
      $display("FAIL %s reset_state: rdy=%b busy=%b done=%b q=%0d r=%0d dbz=%b want 1 0 0 0 0 0",
               name, bus.ready, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_reset();
    check_reset_outs("reset");
  endtask

  task automatic test_basic();
    issue(8'd100, 8'd7, 1);
    wait_done("div_100_7", 0);
    @(negedge clk);
`ifndef DIV_SIGNED_EN
    issue(8'd250, 8'd130, 1);
    wait_done("div_250_130", 0);
    @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back();
    issue(8'd255, 8'd1, 1);
    wait_done("div_255_1", 0);
    issue(8'd3, 8'd200, 1);
    wait_done("b2b_3_200", 0);
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    issue(8'd5, 8'd0, 1);
    wait_done("div_5_0", 0);
    @(negedge clk);
    issue(8'd9, 8'd3, 1);
    wait_done("div_9_3", 0);
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    issue(8'd100, 8'd7, 1);
    wait_done("ignore_start", 1);
    expect_quiet("ignore_start", 12);
  endtask

  task automatic test_rst_mid_run();
    issue(8'd77, 8'd5, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("rst_mid_run");
    rst = 1'b0;
    expect_quiet("rst_mid_run", 11);
    issue(8'd50, 8'd6, 1);
    wait_done("div_50_6", 0);
    @(negedge clk);
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    issue(8'h9C, 8'd7, 1);
    wait_done("s_m100_7", 0);
    issue(8'd100, 8'hF9, 1);
    wait_done("s_100_m7", 0);
    issue(8'h80, 8'hFF, 1);
    wait_done("s_min_m1", 0);
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_rst_mid_run();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    nchk++;
    if (sb.size() != 0) begin
      nerr++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
